// File: rtl/bcd_scan_counter.sv
// N-digit BCD up/down counter with a time-multiplexed, common-anode 7-segment scan driver.
// The count and scan prescalers are independent; AN and dec_out are registered.
module bcd_scan_counter #(
    parameter int CLK_HZ   = 100_000_000,
    parameter int COUNT_HZ = 1,
    parameter int SCAN_HZ  = 1000,
    parameter int N_DIGITS = 4,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic                CLK100MHz,
    input  logic                RST,
    input  logic                EN,
    input  logic                UP,
    input  logic                CLR,
    output logic                LED,
    output logic                WRAP,
    output logic [N_DIGITS-1:0] AN,
    output logic [6:0]          dec_out
);

    localparam int CNT_DIV  = CLK_HZ / COUNT_HZ;
    localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
    localparam int CNT_W    = $clog2(CNT_DIV);
    localparam int SCAN_W   = $clog2(SCAN_DIV);
    localparam int IDX_W    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(CNT_DIV - 1);
    localparam logic [CNT_W-1:0]    CNT_ZERO   = CNT_W'(0);
    localparam logic [CNT_W-1:0]    CNT_ONE    = CNT_W'(1);
    localparam logic [SCAN_W-1:0]   SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [SCAN_W-1:0]   SCAN_ZERO  = SCAN_W'(0);
    localparam logic [SCAN_W-1:0]   SCAN_ONE   = SCAN_W'(1);
    localparam logic [IDX_W-1:0]    IDX_LAST   = IDX_W'(N_DIGITS - 1);
    localparam logic [IDX_W-1:0]    IDX_ZERO   = IDX_W'(0);
    localparam logic [IDX_W-1:0]    IDX_ONE    = IDX_W'(1);
    localparam logic [N_DIGITS-1:0] AN_RESET   = ~(N_DIGITS'(1));
    localparam logic [6:0]          SEG_ZERO   = 7'b0000001;
    localparam logic [6:0]          SEG_BLANK  = 7'b1111111;

    // Active-low {a,b,c,d,e,f,g}; any non-BCD code shows nothing.
    function automatic logic [6:0] seg_encode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'b0000001;
            4'd1:    seg = 7'b1001111;
            4'd2:    seg = 7'b0010010;
            4'd3:    seg = 7'b0000110;
            4'd4:    seg = 7'b1001100;
            4'd5:    seg = 7'b0100100;
            4'd6:    seg = 7'b0100000;
            4'd7:    seg = 7'b0001111;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0000100;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

    // One BCD digit step: returns {carry/borrow out, next digit}. Out-of-range codes recover.
    function automatic logic [4:0] bcd_step(input logic [3:0] digit, input logic up, input logic cin);
        logic [4:0] res;
        if (!cin) begin
            res = {1'b0, digit};
        end else if (up) begin
            if (digit >= 4'd9) begin
                res = {1'b1, 4'd0};
            end else begin
                res = {1'b0, digit + 4'd1};
            end
        end else begin
            if (digit == 4'd0) begin
                res = {1'b1, 4'd9};
            end else if (digit > 4'd9) begin
                res = {1'b0, 4'd9};
            end else begin
                res = {1'b0, digit - 4'd1};
            end
        end
        return res;
    endfunction

    logic [CNT_W-1:0]             cnt_pre_r;
    logic [SCAN_W-1:0]            scan_pre_r;
    logic [IDX_W-1:0]             scan_idx_r;
    logic [N_DIGITS-1:0][3:0]     digits_r;
    logic                         wrap_r;
    logic [N_DIGITS-1:0]          an_r;
    logic [6:0]                   seg_r;

    logic                         tick_s;
    logic                         scan_tick_s;
    logic [N_DIGITS:0]            carry_s;
    logic [N_DIGITS-1:0][3:0]     digits_next_s;
    logic                         wrap_s;
    logic [N_DIGITS:0]            zero_above_s;
    logic [N_DIGITS-1:0]          blank_s;
    logic [N_DIGITS-1:0]          hit_s;
    logic [3:0]                   sel_digit_s;
    logic                         sel_blank_s;
    logic [N_DIGITS-1:0]          an_next_s;
    logic [6:0]                   seg_next_s;

    // Prescaler terminal counts; the count tick only exists while counting is enabled.
    always_comb begin
        tick_s      = EN & (cnt_pre_r == CNT_LAST);
        scan_tick_s = (scan_pre_r == SCAN_LAST);
    end

    // Ripple carry/borrow chain seeded by the tick; a carry out of the top digit is a full wrap.
    always_comb begin
        carry_s       = {(N_DIGITS + 1){1'b0}};
        digits_next_s = digits_r;
        carry_s[0]    = tick_s;
        for (int i = 0; i < N_DIGITS; i++) begin
            {carry_s[i+1], digits_next_s[i]} = bcd_step(digits_r[i], UP, carry_s[i]);
        end
        wrap_s = carry_s[N_DIGITS];
    end

    // Count prescaler, digit register and wrap pulse; CLR overrides a same-cycle tick.
    always_ff @(posedge CLK100MHz or posedge RST) begin
        if (RST) begin
            cnt_pre_r <= CNT_ZERO;
            digits_r  <= {N_DIGITS{4'd0}};
            wrap_r    <= 1'b0;
        end else if (CLR) begin
            cnt_pre_r <= CNT_ZERO;
            digits_r  <= {N_DIGITS{4'd0}};
            wrap_r    <= 1'b0;
        end else begin
            if (tick_s) begin
                cnt_pre_r <= CNT_ZERO;
            end else if (EN) begin
                cnt_pre_r <= cnt_pre_r + CNT_ONE;
            end else begin
                cnt_pre_r <= cnt_pre_r;
            end
            digits_r <= digits_next_s;
            wrap_r   <= wrap_s;
        end
    end

    // Free-running scan prescaler and digit index, untouched by EN and CLR.
    always_ff @(posedge CLK100MHz or posedge RST) begin
        if (RST) begin
            scan_pre_r <= SCAN_ZERO;
            scan_idx_r <= IDX_ZERO;
        end else if (scan_tick_s) begin
            scan_pre_r <= SCAN_ZERO;
            if (scan_idx_r == IDX_LAST) begin
                scan_idx_r <= IDX_ZERO;
            end else begin
                scan_idx_r <= scan_idx_r + IDX_ONE;
            end
        end else begin
            scan_pre_r <= scan_pre_r + SCAN_ONE;
            scan_idx_r <= scan_idx_r;
        end
    end

    // A digit above 0 is blanked when it and every more significant digit are zero.
    always_comb begin
        zero_above_s           = {(N_DIGITS + 1){1'b0}};
        blank_s                = {N_DIGITS{1'b0}};
        zero_above_s[N_DIGITS] = 1'b1;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            zero_above_s[i] = zero_above_s[i+1] & (digits_r[i] == 4'd0);
        end
        for (int i = 1; i < N_DIGITS; i++) begin
            blank_s[i] = BLANK_LZ & zero_above_s[i];
        end
    end

    // One-hot select of the scanned digit, built as an AND-OR mux.
    always_comb begin
        hit_s       = {N_DIGITS{1'b0}};
        sel_digit_s = 4'd0;
        sel_blank_s = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            hit_s[i]    = (scan_idx_r == IDX_W'(i));
            sel_digit_s = sel_digit_s | (digits_r[i] & {4{hit_s[i]}});
            sel_blank_s = sel_blank_s | (blank_s[i] & hit_s[i]);
        end
        an_next_s = ~hit_s;
        if (sel_blank_s) begin
            seg_next_s = SEG_BLANK;
        end else begin
            seg_next_s = seg_encode(sel_digit_s);
        end
    end

    // Registered anode and segment drive, one cycle behind index and digits.
    always_ff @(posedge CLK100MHz or posedge RST) begin
        if (RST) begin
            an_r  <= AN_RESET;
            seg_r <= SEG_ZERO;
        end else begin
            an_r  <= an_next_s;
            seg_r <= seg_next_s;
        end
    end

    assign AN      = an_r;
    assign dec_out = seg_r;
    assign WRAP    = wrap_r;
    assign LED     = digits_r[0][0];

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Bench for bcd_scan_counter: two instances (blanking on/off) checked every cycle against
// an integer-valued reference model plus directed scan-order and blanking tables.
module tb_bcd_scan_counter;

    localparam int CNT_DIV  = 10;
    localparam int SCAN_DIV = 2;

    logic       CLK100MHz;
    logic       RST;
    logic       EN;
    logic       UP;
    logic       CLR;
    logic       LED_b, WRAP_b, LED_f, WRAP_f;
    logic [3:0] AN_b, AN_f;
    logic [6:0] dec_out_b, dec_out_f;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state (values after the most recent edge)
    int         m_count;
    int         m_pre;
    int         m_spre;
    int         m_sidx;
    bit         m_wrap;
    logic [3:0] exp_an;
    logic [6:0] exp_seg_b;
    logic [6:0] exp_seg_f;

    logic [6:0] seg_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                                 7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

    bcd_scan_counter #(.CLK_HZ(100), .COUNT_HZ(10), .SCAN_HZ(50), .N_DIGITS(4), .BLANK_LZ(1'b1)) u_dut_blank (
        .CLK100MHz(CLK100MHz), .RST(RST), .EN(EN), .UP(UP), .CLR(CLR),
        .LED(LED_b), .WRAP(WRAP_b), .AN(AN_b), .dec_out(dec_out_b));

    bcd_scan_counter #(.CLK_HZ(100), .COUNT_HZ(10), .SCAN_HZ(50), .N_DIGITS(4), .BLANK_LZ(1'b0)) u_dut_full (
        .CLK100MHz(CLK100MHz), .RST(RST), .EN(EN), .UP(UP), .CLR(CLR),
        .LED(LED_f), .WRAP(WRAP_f), .AN(AN_f), .dec_out(dec_out_f));

    initial CLK100MHz = 1'b0;
    always #5 CLK100MHz = ~CLK100MHz;

    function automatic logic [6:0] model_seg(input int count, input int idx, input bit blank_lz);
        int div;
        div = 1;
        for (int k = 0; k < idx; k++) div = div * 10;
        if (blank_lz && idx > 0 && count < div) return 7'b1111111;
        return seg_tab[(count / div) % 10];
    endfunction

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed=%b expected=%b (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        m_count   = 0;
        m_pre     = 0;
        m_spre    = 0;
        m_sidx    = 0;
        m_wrap    = 1'b0;
        exp_an    = 4'b1110;
        exp_seg_b = 7'b0000001;
        exp_seg_f = 7'b0000001;
    endtask

    task automatic check_all();
        logic [6:0] led_exp;
        led_exp = 7'((m_count % 10) % 2);
        chk("AN_b",   {3'b000, AN_b},   {3'b000, exp_an});
        chk("AN_f",   {3'b000, AN_f},   {3'b000, exp_an});
        chk("seg_b",  dec_out_b,        exp_seg_b);
        chk("seg_f",  dec_out_f,        exp_seg_f);
        chk("LED_b",  {6'd0, LED_b},    led_exp);
        chk("LED_f",  {6'd0, LED_f},    led_exp);
        chk("WRAP_b", {6'd0, WRAP_b},   {6'd0, m_wrap});
        chk("WRAP_f", {6'd0, WRAP_f},   {6'd0, m_wrap});
    endtask

    // One clock: advance the model with the inputs present at the edge, then check #1 later.
    task automatic step();
        logic [3:0] one;
        one = 4'b0001;
        @(posedge CLK100MHz);
        if (RST) begin
            model_reset();
        end else begin
            exp_an    = ~(one << m_sidx);
            exp_seg_b = model_seg(m_count, m_sidx, 1'b1);
            exp_seg_f = model_seg(m_count, m_sidx, 1'b0);
            if (m_spre == SCAN_DIV - 1) begin
                m_spre = 0;
                m_sidx = (m_sidx + 1) % 4;
            end else begin
                m_spre++;
            end
            if (CLR) begin
                m_count = 0;
                m_pre   = 0;
                m_wrap  = 1'b0;
            end else if (EN && m_pre == CNT_DIV - 1) begin
                m_pre = 0;
                if (UP) begin
                    m_wrap  = (m_count == 9999);
                    m_count = (m_count + 1) % 10000;
                end else begin
                    m_wrap  = (m_count == 0);
                    m_count = (m_count + 9999) % 10000;
                end
            end else begin
                m_wrap = 1'b0;
                if (EN) m_pre++;
            end
        end
        #1;
        check_all();
    endtask

    task automatic do_reset();
        #2 RST = 1'b1;
        #1 model_reset();
        check_all();
        step();
        #2 RST = 1'b0;
    endtask

    task automatic run_until(input int target, input int budget, input bit en_rand, input string tag);
        int n;
        n = 0;
        while (m_count != target && n < budget) begin
            if (en_rand) EN = ($urandom_range(0, 7) != 0);
            else EN = 1'b1;
            step();
            n++;
        end
        EN = 1'b1;
        n_assert++;
        assert (m_count == target) else begin
            n_fail++;
            $error("FAIL %s: timeout, model count=%0d required=%0d", tag, m_count, target);
        end
    endtask

    task automatic sync_scan();
        int n;
        n = 0;
        while (!(m_sidx == 0 && m_spre == 0) && n < 8) begin
            step();
            n++;
        end
    endtask

    logic [3:0] an_seq   [8] = '{4'b1110, 4'b1110, 4'b1101, 4'b1101, 4'b1011, 4'b1011, 4'b0111, 4'b0111};
    logic [6:0] seg1234  [4] = '{7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111};
    logic [6:0] seg42_b  [4] = '{7'b0010010, 7'b1001100, 7'b1111111, 7'b1111111};
    logic [6:0] seg42_f  [4] = '{7'b0010010, 7'b1001100, 7'b0000001, 7'b0000001};

    initial begin
        RST = 1'b0; EN = 1'b0; UP = 1'b1; CLR = 1'b0;
        model_reset();
        #1 RST = 1'b1;
        #1 check_all();
        #10 RST = 1'b0;

        // Count up a little, then hit RST between edges
        EN = 1'b1; UP = 1'b1;
        repeat (25) step();
        #3 RST = 1'b1;
        #1 model_reset();
        check_all();
        repeat (2) step();
        #2 RST = 1'b0;
        repeat (9) step();
        chk("first_tick_pre", {6'd0, LED_b}, 7'd0);
        step();
        chk("first_tick", {6'd0, LED_b}, 7'd1);

        // Down wrap from zero
        do_reset();
        EN = 1'b1; UP = 1'b0;
        repeat (10) step();
        chk("down_wrap", {6'd0, WRAP_b}, 7'd1);
        step();
        chk("down_wrap_once", {6'd0, WRAP_b}, 7'd0);
        repeat (9) step();

        // Up wrap 9999 -> 0
        UP = 1'b1;
        run_until(9999, 200, 1'b0, "to_9999");
        run_until(0, 200, 1'b0, "to_0");
        chk("up_wrap", {6'd0, WRAP_b}, 7'd1);
        step();
        chk("up_wrap_once", {6'd0, WRAP_b}, 7'd0);

        // Carries and borrow with random pauses
        run_until(100, 3000, 1'b1, "to_100");
        run_until(1000, 20000, 1'b1, "to_1000");
        UP = 1'b0;
        run_until(999, 300, 1'b1, "to_999");
        UP = 1'b1;
        run_until(1234, 6000, 1'b1, "to_1234");

        // Scan order at 1234
        EN = 1'b0;
        sync_scan();
        for (int k = 0; k < 8; k++) begin
            step();
            chk("scan_an", {3'b000, AN_b}, {3'b000, an_seq[k]});
            chk("scan_seg", dec_out_b, seg1234[k/2]);
        end

        // Blanking at 0042, including a long pause
        do_reset();
        UP = 1'b1;
        run_until(42, 1000, 1'b1, "to_42");
        EN = 1'b0;
        repeat (50) step();
        sync_scan();
        for (int k = 0; k < 8; k++) begin
            step();
            chk("blank_an", {3'b000, AN_b}, {3'b000, an_seq[k]});
            chk("blank_seg_b", dec_out_b, seg42_b[k/2]);
            chk("blank_seg_f", dec_out_f, seg42_f[k/2]);
        end

        // CLR on a tick cycle at 9999 must win and give no WRAP
        UP = 1'b0;
        run_until(9999, 1000, 1'b0, "to_9999_clr");
        UP = 1'b1;
        for (int n = 0; n < 20 && m_pre != CNT_DIV - 1; n++) step();
        CLR = 1'b1;
        step();
        CLR = 1'b0;
        chk("clr_no_wrap", {6'd0, WRAP_b}, 7'd0);
        chk("clr_seg", dec_out_f, 7'b0000100);
        repeat (30) step();
        EN = 1'b0; CLR = 1'b1;
        step();
        CLR = 1'b0;
        repeat (15) step();

        // Random EN/UP/CLR
        for (int n = 0; n < 600; n++) begin
            EN  = ($urandom_range(0, 7) != 0);
            UP  = ($urandom_range(0, 1) != 0);
            CLR = ($urandom_range(0, 31) == 0);
            step();
        end
        CLR = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
